array_host_ctrl: RTL and testbench
==================================

ARRAY_HOST_CTRL -- requirements
Module: array_host_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension.
REQ-002 Parameter DW, default 16: matrix element width.
REQ-003 Parameter AW, default 10: memA/memB address width.
REQ-004 Parameter ROW_STRIDE, default 256: address distance between matrix rows.
REQ-005 Parameters IW, default 4, and IDEPTH, default 8: instruction width and instruction count.
REQ-006 Parameters OW, default 32, and OAW, default 4: result width and result address width.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 start, abort  input  1 each  job start pulse and job abort pulse.
REQ-010 busy, done, err  output  1 each  job in progress; one-cycle completion pulse; timeout flag.
REQ-011 s_valid, s_ready  input/output  1 each  matrix stream handshake.
REQ-012 s_data_a, s_data_b  input  DW each  A and B elements, one beat each.
REQ-013 i_valid, i_ready, i_data  in/out/in  1/1/IW  instruction stream.
REQ-014 m_valid, m_ready, m_data  out/in/out  1/1/OW  result stream.
REQ-015 addrA, dataA, enA, addrB, dataB, enB  output  AW/DW/1 each  array memory write ports.
REQ-016 addrI, dataI, enI  output  clog2(IDEPTH)/IW/1  instruction memory write port.
REQ-017 addrO  output  OAW; dataO  input  OW  result read port, 1-cycle read latency.
REQ-018 ap_start  output  1; ap_done  input  1  array kick and completion.

Function
REQ-019 States: IDLE, LOAD_AB, LOAD_I, KICK, WAIT, DRAIN, DONE.
REQ-020 IDLE->LOAD_AB on start; start outside IDLE is ignored.
REQ-021 LOAD_AB: s_ready=1; each accepted beat writes A and B in the same cycle via enA=enB=1.
REQ-022 LOAD_AB loads N rows x (2N-1) columns, row-major; address = row*ROW_STRIDE + col, equal for A and B.
REQ-023 After the last beat (row N-1, col 2N-2), LOAD_AB->LOAD_I.
REQ-024 LOAD_I: i_ready=1; each accepted beat writes addrI = 0..IDEPTH-1 with enI=1.
REQ-025 After IDEPTH beats, LOAD_I->KICK.
REQ-026 KICK lasts exactly one cycle with ap_start=1, then ->WAIT; ap_start=0 in every other state.
REQ-027 WAIT: ap_done sampled high ->DRAIN.
REQ-028 DRAIN reads N*N results, addrO = 0..N*N-1; issues address, captures dataO next cycle into m_data, holds m_valid=1 until m_ready, then issues next address.
REQ-029 When the last result is accepted, DRAIN->DONE.
REQ-030 DONE lasts one cycle: done=1, ->IDLE.
REQ-031 busy=1 in every state except IDLE.
REQ-032 Write enables are high only on handshake cycles; no write occurs when the valid input is low.
REQ-033 abort in any non-IDLE state: next state IDLE, all enables and ap_start low, no done pulse; abort has priority over every other transition.
REQ-034 Counters hold their value when the stream is stalled; column counter wraps 2N-2->0 with row increment.

Reset
REQ-035 rst=0 at a clock edge: state IDLE, counters 0, err=0.
REQ-036 Outputs under reset: busy, done, s_ready, i_ready, m_valid, enA, enB, enI, ap_start all 0; addresses and data outputs 0.
REQ-037 Reset mid-job discards the job; no write or pulse occurs on the following cycle.

Configuration
REQ-038 Macro ARRAY_HOST_TIMEOUT_EN, when defined, adds parameter TIMEOUT, default 1024, and a WAIT-cycle counter.
REQ-039 With ARRAY_HOST_TIMEOUT_EN, reaching TIMEOUT cycles in WAIT without ap_done: ->DONE, err=1 until the next start, DRAIN skipped.
REQ-040 Without ARRAY_HOST_TIMEOUT_EN: err is tied 0 and WAIT is unbounded.

Structure
REQ-041 A shared package array_pkg holds the state enum, default widths, and the ROW_STRIDE constant.
REQ-042 One sub-module, array_rc_counter (row/column counter with wrap and last flag), serves LOAD_AB and DRAIN.

Verification
REQ-043 N=4: 28 beats, band pattern of ones (row i, cols i..i+3) -> addrA/addrB sequence 0..6, 256..262, 512..518, 768..774, data matching.
REQ-044 Instructions 4,0,2,1,0,0,0,0 -> addrI 0..7 with those values, then ap_start high exactly one cycle.
REQ-045 Stub raises ap_done 20 cycles after ap_start; dataO=addr+100; m_ready toggling -> 16 results 100..115 in order, then a done pulse.
REQ-046 s_valid deasserted mid-row 3 for 5 cycles -> no writes during the gap, addresses resume without skip.
REQ-047 rst low during LOAD_AB beat 10 -> next cycle all enables 0 and busy 0; a new start reloads from address 0.
REQ-048 ARRAY_HOST_TIMEOUT_EN, TIMEOUT=50, ap_done never asserted -> done pulse 50 cycles into WAIT with err=1 and m_valid never asserted.

Source files
------------

// File: rtl/array_pkg.sv
// array_pkg: shared FSM state enum, default widths and row stride for the array host controller.
package array_pkg;
  localparam int DEF_N          = 4;
  localparam int DEF_DW         = 16;
  localparam int DEF_AW         = 10;
  localparam int DEF_ROW_STRIDE = 256;
  localparam int DEF_IW         = 4;
  localparam int DEF_IDEPTH     = 8;
  localparam int DEF_OW         = 32;
  localparam int DEF_OAW        = 4;
  localparam int DEF_TIMEOUT    = 1024;

  typedef enum logic [2:0] {IDLE, LOAD_AB, LOAD_I, KICK, WAIT, DRAIN, DONE} hostState_e;

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/array_host_ctrl_if.sv
// array_host_ctrl_if: matrix, instruction and result streams of the array host controller.
interface array_host_ctrl_if import array_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int IW = DEF_IW,
  parameter int OW = DEF_OW
) ();
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data_a, s_data_b;
  logic          i_valid, i_ready;
  logic [IW-1:0] i_data;
  logic          m_valid, m_ready;
  logic [OW-1:0] m_data;

  modport slave (
    input  s_valid, s_data_a, s_data_b, i_valid, i_data, m_ready,
    output s_ready, i_ready, m_valid, m_data
  );
  modport master (
    output s_valid, s_data_a, s_data_b, i_valid, i_data, m_ready,
    input  s_ready, i_ready, m_valid, m_data
  );
endinterface

// File: rtl/array_rc_counter.sv
// array_rc_counter: row/column walker; column wraps into the next row, whole count wraps after the last cell.
module array_rc_counter import array_pkg::*; #(
  parameter int ROWS = DEF_N,
  parameter int COLS = 2*DEF_N-1,
  parameter int RW   = cntW(ROWS),
  parameter int CW   = cntW(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  assign last = (row == RW'(ROWS-1)) && (col == CW'(COLS-1));

  // Step on inc only, so a stalled stream leaves the position untouched.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == CW'(COLS-1)) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/array_host_ctrl.sv
// array_host_ctrl: loads A/B and instruction memories, kicks the systolic array, drains results.
// Optional macro ARRAY_HOST_TIMEOUT_EN bounds WAIT by TIMEOUT cycles and raises err on expiry.
module array_host_ctrl import array_pkg::*; #(
  parameter int N          = DEF_N,
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int IW         = DEF_IW,
  parameter int IDEPTH     = DEF_IDEPTH,
  parameter int OW         = DEF_OW,
  parameter int OAW        = DEF_OAW
`ifdef ARRAY_HOST_TIMEOUT_EN
  , parameter int TIMEOUT  = DEF_TIMEOUT
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  array_host_ctrl_if.slave          bus,
  output logic [AW-1:0]             addrA,
  output logic [DW-1:0]             dataA,
  output logic                      enA,
  output logic [AW-1:0]             addrB,
  output logic [DW-1:0]             dataB,
  output logic                      enB,
  output logic [$clog2(IDEPTH)-1:0] addrI,
  output logic [IW-1:0]             dataI,
  output logic                      enI,
  output logic [OAW-1:0]            addrO,
  input  logic [OW-1:0]             dataO,
  output logic                      ap_start,
  input  logic                      ap_done
);
  localparam int IIW = $clog2(IDEPTH);
  localparam int RC  = 2*N-1;

  hostState_e        state, nextState;
  logic [cntW(N)-1:0]  abRow, drRow, drCol;
  logic [cntW(RC)-1:0] abCol;
  logic                abLast, drLast;
  logic [IIW-1:0]      iCnt;
  logic                rdPend, mValidR;
  logic [OW-1:0]       mDataR;
  logic                sHs, iHs, mHs, timeout;

  // Readies are withheld during reset and abort so no write slips through on those cycles.
  assign bus.s_ready = rst && !abort && (state == LOAD_AB);
  assign bus.i_ready = rst && !abort && (state == LOAD_I);
  assign sHs = bus.s_ready && bus.s_valid;
  assign iHs = bus.i_ready && bus.i_valid;
  assign mHs = bus.m_valid && bus.m_ready && (state == DRAIN);

  assign enA   = sHs;
  assign enB   = sHs;
  assign addrA = rst ? AW'(int'(abRow) * ROW_STRIDE + int'(abCol)) : '0;
  assign addrB = addrA;
  assign dataA = sHs ? bus.s_data_a : '0;
  assign dataB = sHs ? bus.s_data_b : '0;
  assign enI   = iHs;
  assign addrI = rst ? iCnt : '0;
  assign dataI = iHs ? bus.i_data : '0;
  assign addrO = rst ? OAW'(int'(drRow) * N + int'(drCol)) : '0;

  assign bus.m_valid = rst && mValidR;
  assign bus.m_data  = rst ? mDataR : '0;
  assign ap_start    = rst && !abort && (state == KICK);
  assign busy        = rst && (state != IDLE);
  assign done        = rst && !abort && (state == DONE);

  array_rc_counter #(.ROWS(N), .COLS(RC)) abCnt (
    .clk(clk), .rst(rst), .clr(state == IDLE), .inc(sHs),
    .row(abRow), .col(abCol), .last(abLast)
  );

  array_rc_counter #(.ROWS(N), .COLS(N)) drCnt (
    .clk(clk), .rst(rst), .clr(state == IDLE), .inc(mHs),
    .row(drRow), .col(drCol), .last(drLast)
  );

  // Instruction write pointer, parked at 0 outside a job.
  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) iCnt <= '0;
    else if (iHs)              iCnt <= iCnt + IIW'(1);
  end

`ifdef ARRAY_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] waitCnt;
  logic          errR;

  assign timeout = (waitCnt == TW'(TIMEOUT-1));
  assign err     = rst && errR;

  // Cycles spent in WAIT; restarts from 0 on every entry.
  always_ff @(posedge clk) begin
    if (!rst || state != WAIT) waitCnt <= '0;
    else                       waitCnt <= waitCnt + TW'(1);
  end

  // Sticky timeout flag, cleared when the next job starts.
  always_ff @(posedge clk) begin
    if (!rst)                                               errR <= 1'b0;
    else if (state == IDLE && start)                        errR <= 1'b0;
    else if (state == WAIT && timeout && !ap_done && !abort) errR <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state; abort overrides every other transition.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)           nextState = LOAD_AB;
      LOAD_AB: if (sHs && abLast)   nextState = LOAD_I;
      LOAD_I:  if (iHs && iCnt == IIW'(IDEPTH-1)) nextState = KICK;
      KICK:                         nextState = WAIT;
      WAIT:    if (ap_done)         nextState = DRAIN;
               else if (timeout)    nextState = DONE;
      DRAIN:   if (mHs && drLast)   nextState = DONE;
      DONE:                         nextState = IDLE;
      default:                      nextState = IDLE;
    endcase
    if (abort && state != IDLE) nextState = IDLE;
  end

  // Drain sequencing: issue address, capture read data a cycle later, hold until taken.
  always_ff @(posedge clk) begin
    if (!rst || abort || state != DRAIN) begin
      rdPend  <= 1'b0;
      mValidR <= 1'b0;
    end else if (rdPend) begin
      rdPend  <= 1'b0;
      mValidR <= 1'b1;
    end else if (mValidR) begin
      if (bus.m_ready) mValidR <= 1'b0;
    end else begin
      rdPend <= 1'b1;
    end
  end

  // Result holding register, loaded from the one-cycle-late read data.
  always_ff @(posedge clk) begin
    if (!rst)        mDataR <= '0;
    else if (rdPend) mDataR <= dataO;
  end
endmodule

// File: tb/tb_array_host_ctrl.sv
// tb_array_host_ctrl: directed bench for array_host_ctrl (N=4); timeout case under ARRAY_HOST_TIMEOUT_EN.
module tb_array_host_ctrl;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, apDone = 1'b0;
  logic        busy, done, err, enA, enB, enI, apStart;
  logic [9:0]  addrA, addrB;
  logic [15:0] dataA, dataB;
  logic [2:0]  addrI;
  logic [3:0]  dataI;
  logic [3:0]  addrO;
  logic [31:0] dataO = '0;
  logic [3:0]  instr [8];
  int total = 0, passed = 0, failed = 0;

  array_host_ctrl_if #(.DW(16), .IW(4), .OW(32)) bus ();

  array_host_ctrl #(
`ifdef ARRAY_HOST_TIMEOUT_EN
    .TIMEOUT(50),
`endif
    .N(4), .DW(16), .AW(10), .ROW_STRIDE(256), .IW(4), .IDEPTH(8), .OW(32), .OAW(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .bus(bus),
    .addrA(addrA), .dataA(dataA), .enA(enA),
    .addrB(addrB), .dataB(dataB), .enB(enB),
    .addrI(addrI), .dataI(dataI), .enI(enI),
    .addrO(addrO), .dataO(dataO),
    .ap_start(apStart), .ap_done(apDone)
  );

  always #5 clk = ~clk;

  // Result memory stub: one-cycle read latency, content = address + 100.
  always @(posedge clk) dataO <= 32'(addrO) + 32'd100;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] band(input int r, input int c);
    return (c >= r && c <= r + 3) ? 16'd1 : 16'd0;
  endfunction

  initial begin
    int  got, cycles;
    bit  sawBad;
    instr = '{4'd4, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    bus.s_valid = 1'b0; bus.s_data_a = '0; bus.s_data_b = '0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.m_ready = 1'b0;

    // Reset state
    rst = 1'b0; cyc(); cyc();
    @(negedge clk);
    check("rst busy/done/err", {busy, done, err}, 3'b000);
    check("rst readies", {bus.s_ready, bus.i_ready, bus.m_valid}, 3'b000);
    check("rst enables", {enA, enB, enI, apStart}, 4'b0000);
    check("rst addresses", {addrA, addrB, addrI, addrO, bus.m_data}, '0);
    rst = 1'b1; cyc();
    @(negedge clk);
    check("idle quiet", {busy, bus.s_ready}, 2'b00);

    // Full job: 28 band beats with a 5-cycle gap mid-row 3
    start = 1'b1; cyc(); start = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 7; c++) begin
        if (r == 3 && c == 3) begin
          bus.s_valid = 1'b0;
          for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check("gap no write", {enA, enB, bus.s_ready, addrA}, {1'b0, 1'b0, 1'b1, 10'(3*256+3)});
            cyc();
          end
        end
        bus.s_valid = 1'b1; bus.s_data_a = band(r, c); bus.s_data_b = band(r, c);
        @(negedge clk);
        check("ab beat", {enA, enB, addrA, addrB, dataA, dataB},
              {2'b11, 10'(r*256+c), 10'(r*256+c), band(r, c), band(r, c)});
        cyc();
      end
    bus.s_valid = 1'b0;

    // Instruction load
    @(negedge clk);
    check("load_i entry", {bus.s_ready, bus.i_ready, enI}, 3'b010);
    cyc();
    for (int k = 0; k < 8; k++) begin
      bus.i_valid = 1'b1; bus.i_data = instr[k];
      @(negedge clk);
      check("instr write", {apStart, enI, addrI, dataI}, {1'b0, 1'b1, 3'(k), instr[k]});
      cyc();
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("kick", {apStart, busy}, 2'b11);
    cyc();
    @(negedge clk);
    check("kick one cycle", apStart, 1'b0);

    // ap_done 20 cycles after ap_start
    repeat (19) cyc();
    @(negedge clk);
    check("wait quiet", {busy, bus.m_valid, done}, 3'b100);
    apDone = 1'b1; cyc(); apDone = 1'b0;

    // Drain with toggling m_ready
    got = 0; cycles = 0;
    while (got < 16 && cycles < 400) begin
      bus.m_ready = cycles[0];
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        check("result", bus.m_data, 64'(100 + got));
        got++;
      end
      cyc();
      cycles++;
    end
    bus.m_ready = 1'b0;
    check("result count", 64'(got), 64'd16);
    @(negedge clk);
    check("done pulse", {done, busy, err}, 3'b110);
    cyc();
    @(negedge clk);
    check("back to idle", {done, busy}, 2'b00);

    // Abort mid LOAD_AB
    start = 1'b1; cyc(); start = 1'b0;
    bus.s_valid = 1'b1; bus.s_data_a = 16'h5; bus.s_data_b = 16'h5;
    cyc(); cyc(); cyc();
    abort = 1'b1;
    @(negedge clk);
    check("abort blocks write", {enA, enB, apStart, done}, 4'b0000);
    cyc(); abort = 1'b0;
    @(negedge clk);
    check("abort to idle", {busy, done, enA}, 3'b000);

    // Reset during LOAD_AB beat 10, then restart from address 0
    start = 1'b1; cyc(); start = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    check("beat 10 addr", {enA, addrA}, {1'b1, 10'd259});
    rst = 1'b0; #1;
    check("reset gates write", {enA, enB, busy}, 3'b000);
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("after reset", {enA, enB, busy, bus.s_ready, addrA}, '0);
    start = 1'b1; cyc(); start = 1'b0;
    @(negedge clk);
    check("reload from 0", {enA, addrA, dataA}, {1'b1, 10'd0, 16'h5});
    abort = 1'b1; cyc(); abort = 1'b0;
    bus.s_valid = 1'b0;

`ifdef ARRAY_HOST_TIMEOUT_EN
    // Timeout: ap_done never arrives
    start = 1'b1; cyc(); start = 1'b0;
    bus.s_valid = 1'b1; repeat (28) cyc(); bus.s_valid = 1'b0;
    bus.i_valid = 1'b1; repeat (8) cyc(); bus.i_valid = 1'b0;
    @(negedge clk);
    check("to kick", apStart, 1'b1);
    cyc();
    sawBad = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (done || bus.m_valid) sawBad = 1'b1;
      cyc();
    end
    check("wait silent", sawBad, 1'b0);
    @(negedge clk);
    check("timeout done", {done, err, bus.m_valid}, 3'b110);
    cyc();
    @(negedge clk);
    check("err holds", {busy, err}, 2'b01);
    start = 1'b1; cyc(); start = 1'b0;
    @(negedge clk);
    check("err clears", err, 1'b0);
    abort = 1'b1; cyc(); abort = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
